// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage; stalls the pipeline while it runs.
// Build option: define MUL_SEQ_MAC_EN to add the MAC accumulator and acc_clear handling.
module mul_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             acc_clear,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CYCLES = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);
  localparam logic [3:0] CODE_MUL = 4'd8;
  localparam logic [3:0] CODE_MAC = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [WIDTH-1:0]                mcand_q, mcand_d;
  logic [WIDTH-1:0]                mplier_q, mplier_d;
  logic [WIDTH-1:0]                partial_q, partial_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [WIDTH-1:0]                result_q, result_d;
  logic [WIDTH+BITS_PER_CYCLE-1:0] step_prod;
  logic [WIDTH-1:0]                done_value;
  logic                            is_mul_code;
  logic                            accept;

  // The multiplicand is kept pre-shifted and the multiplier pre-shifted down, so each
  // iteration always multiplies by the lowest chunk.
  assign step_prod = {{BITS_PER_CYCLE{1'b0}}, mcand_q}
                   * {{WIDTH{1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};

  assign is_mul_code = (alu_control == CODE_MUL) || (alu_control == CODE_MAC);
  assign accept      = (state_q == IDLE) && start && is_mul_code && !flush;

`ifdef MUL_SEQ_MAC_EN
  logic             is_mac_q, is_mac_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // A clear coinciding with the commit acts as clear-then-add.
  assign done_value = is_mac_q ? ((acc_clear ? '0 : acc_q) + partial_q) : partial_q;
`else
  logic unused_acc_clear;
  assign unused_acc_clear = acc_clear;
  assign done_value       = partial_q;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
`ifdef MUL_SEQ_MAC_EN
    is_mac_d = is_mac_q;
    acc_d    = acc_clear ? '0 : acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d   = op_a;
          mplier_d  = op_b;
          partial_d = '0;
          cnt_d     = '0;
          state_d   = RUN;
`ifdef MUL_SEQ_MAC_EN
          is_mac_d = (alu_control == CODE_MAC);
`endif
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          partial_d = partial_q + step_prod[WIDTH-1:0];
          mcand_d   = mcand_q << BITS_PER_CYCLE;
          mplier_d  = mplier_q >> BITS_PER_CYCLE;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          result_d = done_value;
`ifdef MUL_SEQ_MAC_EN
          if (is_mac_q) begin
            acc_d = done_value;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
`ifdef MUL_SEQ_MAC_EN
      is_mac_q <= 1'b0;
      acc_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
`ifdef MUL_SEQ_MAC_EN
      is_mac_q <= is_mac_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign stall        = accept || (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign result_valid = (state_q == DONE) && !flush;
  assign result       = (state_q == DONE) ? done_value : result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: vector table of back-to-back ops plus flush/reset sequences.
module tb_mul_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alu_control = 4'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         acc_clear = 1'b0;
  logic         stall;
  logic         result_valid;
  logic [W-1:0] result;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(8)) dut (
    .clk          (clk),
    .arst         (arst),
    .start        (start),
    .alu_control  (alu_control),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .acc_clear    (acc_clear),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One full operation: accept at T, RUN T+1..T+4, DONE at T+5.
  task automatic run_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic clr, input logic [W-1:0] exp);
    @(negedge clk);
    start = 1'b1; alu_control = code; op_a = a; op_b = b; flush = 1'b0; acc_clear = 1'b0;
    #1;
    chk("stall_at_accept", stall, 1);
    chk("busy_at_accept", busy, 0);
    chk("valid_at_accept", result_valid, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      chk("stall_in_run", stall, 1);
      chk("busy_in_run", busy, 1);
      chk("valid_in_run", result_valid, 0);
    end
    @(negedge clk);
    acc_clear = clr;
    #1;
    chk("valid_in_done", result_valid, 1);
    chk("stall_in_done", stall, 0);
    chk("busy_in_done", busy, 0);
    chk("result", result, exp);
    $display("op code=%0d a=0x%08h b=0x%08h clr=%0b result=0x%08h expected=0x%08h",
             code, a, b, clr, result, exp);
    @(posedge clk);
    #1 acc_clear = 1'b0;
  endtask

  initial begin
`ifdef MUL_SEQ_MAC_EN
    vecs[3] = '{4'd9, 32'd5, 32'd5, 1'b0, 32'd37};
    vecs[7] = '{4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0013};
`else
    vecs[3] = '{4'd9, 32'd5, 32'd5, 1'b0, 32'd25};
    vecs[7] = '{4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF};
`endif
    vecs[0]  = '{4'd8, 32'd7, 32'd6, 1'b0, 32'd42};
    vecs[1]  = '{4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
    vecs[2]  = '{4'd9, 32'd3, 32'd4, 1'b0, 32'd12};
    vecs[4]  = '{4'd9, 32'd2, 32'd10, 1'b1, 32'd20};
    vecs[5]  = '{4'd8, 32'h1234_5678, 32'h0000_0010, 1'b0, 32'h2345_6780};
    vecs[6]  = '{4'd8, 32'd0, 32'hDEAD_BEEF, 1'b0, 32'd0};
    vecs[8]  = '{4'd8, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0};
    vecs[9]  = '{4'd8, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 32'h0C37_4FA4};
    vecs[10] = '{4'd8, 32'h0101_0101, 32'h0101_0101, 1'b0, 32'h0403_0201};

    // Reset state
    @(negedge clk);
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_result", result, 0);
    @(negedge clk);
    arst = 1'b0;

    // Back-to-back table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].clr, vecs[i].exp);
    end

    // Non-multiply codes, idle start, and accept blocked by flush
    @(negedge clk);
    start = 1'b1; alu_control = 4'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("nonmul_stall", stall, 0);
      chk("nonmul_busy", busy, 0);
      chk("nonmul_valid", result_valid, 0);
      @(negedge clk);
    end
    start = 1'b0; alu_control = 4'd8;
    #1 chk("nostart_stall", stall, 0);
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1 chk("flush_blocks_accept", stall, 0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1 chk("flush_idle_busy", busy, 0);
    $display("seq nonmul/flush-idle checked");

    // Flush in RUN at T+2 of MUL(9,9)
    @(negedge clk);
    start = 1'b1; alu_control = 4'd8; op_a = 32'd9; op_b = 32'd9;
    #1 chk("flushrun_stall_T", stall, 1);
    @(negedge clk);
    #1 chk("flushrun_busy_T1", busy, 1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flushrun_stall_T2", stall, 1);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flushrun_stall_T3", stall, 0);
    chk("flushrun_busy_T3", busy, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk("flushrun_no_valid", result_valid, 0);
    end
    $display("seq flush-in-run checked");

    // Flush in DONE of MAC(1,1): no result, accumulator untouched
    @(negedge clk);
    start = 1'b1; alu_control = 4'd9; op_a = 32'd1; op_b = 32'd1;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1 chk("flushdone_valid", result_valid, 0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1 chk("flushdone_busy", busy, 0);
    $display("seq flush-in-done checked");
`ifdef MUL_SEQ_MAC_EN
    run_op(4'd9, 32'd0, 32'd0, 1'b0, 32'h0000_0013);
`else
    run_op(4'd9, 32'd0, 32'd0, 1'b0, 32'd0);
`endif

    // Reset mid-RUN, then normal operation resumes
    @(negedge clk);
    start = 1'b1; alu_control = 4'd8; op_a = 32'd100; op_b = 32'd100;
    @(negedge clk);
    @(negedge clk);
    arst = 1'b1; start = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_result", result, 0);
    @(negedge clk);
    arst = 1'b0;
    $display("seq reset-mid-run checked");
    run_op(4'd8, 32'd2, 32'd3, 1'b0, 32'd6);
    run_op(4'd9, 32'd4, 32'd4, 1'b0, 32'd16);

    @(negedge clk);
    start = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
